// File: rtl/sk9822_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : sk9822_monitor
//  Description : Receive-side SK9822/APA102 stream decoder. Synchronises the
//                external LED clock/data pair, frames start/LED/reset/end
//                words, stores LED words in a register file and exposes the
//                register file plus a status word on the Wishbone data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module sk9822_monitor #(
  parameter logic [7:0] ADDR    = 8'd0,
  parameter int         NLEDS   = 12,
  parameter int         TIMEOUT = 1024
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wb_dbus_cyc,
  input  logic        wb_dbus_we,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic        led_ck,
  input  logic        led_data,
  output logic        irq
);

  localparam int              IW     = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]   TMO    = IW'(TIMEOUT);
  localparam logic [IW-1:0]   TMO_M1 = IW'(TIMEOUT - 1);
  localparam logic [3:0]      NL     = 4'(NLEDS);

  typedef enum logic [0:0] {HUNT = 1'b0, DATA = 1'b1} state_t;

  // Synchroniser and edge detect
  logic ck_meta_q, ck_sync_q, ck_prev_q, dat_meta_q, dat_sync_q;
  logic edge_e, bit_s;

  // Decoder state
  state_t          state_q, state_d;
  logic [31:0]     shift_q, shift_d, word;
  logic [4:0]      bitcnt_q, bitcnt_d;
  logic [5:0]      zrun_q, zrun_d;
  logic [3:0]      idx_q, idx_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            latch, mem_we, ferr_set, ovf_set, tmo_set;

  // Register file and status
  logic [31:0]     mem_q [NLEDS];
  logic [7:0]      fcnt_q, fcnt_d;
  logic [3:0]      lcnt_q, lcnt_d;
  logic            ferr_q, ferr_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic            irq_q;

  // Bus
  logic            busy_q, ack_q;
  logic [31:0]     rdata_q, rd_word;
  logic            hit, clr;
  logic [3:0]      rd_idx;

  logic unused_ok;
  assign unused_ok = ^{wb_dbus_dat, wb_dbus_adr[23:6], wb_dbus_adr[1:0]};

  assign edge_e = ck_sync_q & ~ck_prev_q;
  assign bit_s  = dat_sync_q;
  assign word   = {shift_q[30:0], bit_s};

  // Two-flop synchronisers for the asynchronous LED pins, plus edge history
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      ck_meta_q  <= 1'b0;
      ck_sync_q  <= 1'b0;
      ck_prev_q  <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
    end else begin
      ck_meta_q  <= led_ck;
      ck_sync_q  <= ck_meta_q;
      ck_prev_q  <= ck_sync_q;
      dat_meta_q <= led_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Frame decoder: next-state, word classification and idle timeout
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    zrun_d   = zrun_q;
    idx_d    = idx_q;
    idle_d   = idle_q;
    latch    = 1'b0;
    mem_we   = 1'b0;
    ferr_set = 1'b0;
    ovf_set  = 1'b0;
    tmo_set  = 1'b0;
    if (edge_e) begin
      idle_d = '0;
      case (state_q)
        HUNT: begin
          if (bit_s) begin
            zrun_d = '0;
          end else begin
            zrun_d = (zrun_q == 6'd32) ? zrun_q : zrun_q + 6'd1;
            if (zrun_d == 6'd32) begin
              state_d  = DATA;
              idx_d    = '0;
              bitcnt_d = '0;
            end
          end
        end
        default: begin
          // Leading zeros before the first LED word are surplus start-frame bits
          if (!(idx_q == 4'd0 && bitcnt_q == 5'd0 && !bit_s)) begin
            shift_d  = word;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd31) begin
              if (word == 32'hFFFF_FFFF) begin
                latch   = (idx_q != 4'd0);
                state_d = HUNT;
                zrun_d  = '0;
              end else if (word == 32'h0 && idx_q != 4'd0) begin
                latch   = 1'b1;
                state_d = HUNT;
                zrun_d  = '0;
              end else if (word[31:29] == 3'b111) begin
                if (idx_q < NL) mem_we = 1'b1;
                else            ovf_set = 1'b1;
                if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
              end else begin
                ferr_set = 1'b1;
                state_d  = HUNT;
                zrun_d   = '0;
              end
            end
          end
        end
      endcase
    end else begin
      idle_d = (idle_q == TMO) ? idle_q : idle_q + 1'b1;
      // Fires once when the count first reaches the limit, then holds
      if (idle_q == TMO_M1) begin
        tmo_set  = (state_q == DATA) && (bitcnt_q != 5'd0);
        bitcnt_d = '0;
        zrun_d   = '0;
        state_d  = HUNT;
      end
    end
  end

  // Status counters/flags; a same-cycle flag set beats a bus clear
  always_comb begin
    rd_idx = wb_dbus_adr[5:2];
    hit    = wb_dbus_cyc && (wb_dbus_adr[31:24] == ADDR) && !busy_q;
    clr    = hit && wb_dbus_we && (rd_idx == 4'hF);
    fcnt_d = latch ? fcnt_q + 8'd1 : fcnt_q;
    lcnt_d = latch ? idx_q : lcnt_q;
    ferr_d = (ferr_q & ~clr) | ferr_set;
    ovf_d  = (ovf_q  & ~clr) | ovf_set;
    tmo_d  = (tmo_q  & ~clr) | tmo_set;
  end

  // Read mux: reflects this cycle's updates so a colliding read sees new data
  always_comb begin
    rd_word = 32'h0;
    if (rd_idx == 4'hF) begin
      rd_word = {7'b0, (state_d == DATA), 5'b0, tmo_d, ovf_d, ferr_d,
                 4'b0, lcnt_d, fcnt_d};
    end else if (rd_idx < NL) begin
      if (mem_we && idx_q == rd_idx) rd_word = word;
      else                           rd_word = mem_q[rd_idx];
    end
  end

  // Decoder, status and interrupt registers
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q  <= HUNT;
      shift_q  <= '0;
      bitcnt_q <= '0;
      zrun_q   <= '0;
      idx_q    <= '0;
      idle_q   <= '0;
      fcnt_q   <= '0;
      lcnt_q   <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      zrun_q   <= zrun_d;
      idx_q    <= idx_d;
      idle_q   <= idle_d;
      fcnt_q   <= fcnt_d;
      lcnt_q   <= lcnt_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      irq_q    <= latch;
    end
  end

  // LED word register file
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < NLEDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx_q] <= word;
    end
  end

  // Bus handshake: one ack per cycle assertion, re-armed when cyc drops
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      busy_q  <= wb_dbus_cyc ? (busy_q | hit) : 1'b0;
      ack_q   <= hit;
      rdata_q <= hit ? rd_word : 32'h0;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sk9822_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sk9822_monitor
//  Description : Directed self-checking bench for sk9822_monitor. Streams
//                are bit-banged on led_ck/led_data; register reads are
//                scored against a queue of expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sk9822_monitor;

  localparam logic [7:0] ADDR    = 8'h30;
  localparam int         NLEDS   = 12;
  localparam int         TIMEOUT = 1024;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic        cyc = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack, irq;
  logic [31:0] rdata;
  logic        led_ck = 1'b0, led_data = 1'b0;

  int          ncmp = 0;
  int          nerr = 0;
  int          irq_hi = 0;
  logic [31:0] exp_q [$];

  sk9822_monitor #(.ADDR(ADDR), .NLEDS(NLEDS), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .wb_dbus_cyc (cyc),
    .wb_dbus_we  (we),
    .wb_dbus_adr (adr),
    .wb_dbus_dat (dat),
    .ack         (ack),
    .rdata       (rdata),
    .led_ck      (led_ck),
    .led_data    (led_data),
    .irq         (irq)
  );

  always #5 wb_clk = ~wb_clk;

  // Count cycles with irq high; each latch must contribute exactly one
  always @(negedge wb_clk) if (irq === 1'b1) irq_hi++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic w, input logic [3:0] idx,
                          output logic [31:0] d, output logic got);
    int n;
    @(negedge wb_clk);
    cyc = 1'b1; we = w; dat = 32'hDEAD_BEEF;
    adr = {ADDR, 16'h0, 2'b00, idx, 2'b00};
    got = 1'b0; n = 0;
    while (!got && n < 16) begin
      @(posedge wb_clk); #1;
      n++;
      if (ack === 1'b1) got = 1'b1;
    end
    d = rdata;
    @(posedge wb_clk); #1;
    check("ack_single_cycle", {31'b0, ack}, 32'h0);
    @(negedge wb_clk);
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input string tag);
    logic [31:0] d, e;
    logic        got;
    exp_q.push_back(exp);
    bus_xfer(1'b0, idx, d, got);
    check({tag, "_ack"}, {31'b0, got}, 32'h1);
    e = exp_q.pop_front();
    check(tag, d, e);
  endtask

  task automatic wr(input logic [3:0] idx, input string tag);
    logic [31:0] d;
    logic        got;
    bus_xfer(1'b1, idx, d, got);
    check({tag, "_ack"}, {31'b0, got}, 32'h1);
  endtask

  task automatic send_bit(input logic b);
    @(negedge wb_clk);
    led_data = b; led_ck = 1'b0;
    repeat (2) @(negedge wb_clk);
    led_ck = 1'b1;
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[31-i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic settle();
    @(negedge wb_clk);
    led_ck = 1'b0;
    repeat (8) @(negedge wb_clk);
  endtask

  initial begin
    int acks;

    // Reset state
    repeat (3) @(negedge wb_clk);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    wb_rst = 1'b1;
    repeat (2) @(negedge wb_clk);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, "rst_read");

    // Reset in the middle of an LED frame
    send_zeros(32);
    send_word(32'hE100_0000, 20);
    @(negedge wb_clk);
    wb_rst = 1'b0; led_ck = 1'b0;
    repeat (3) @(negedge wb_clk);
    check("midrst_ack", {31'b0, ack}, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    wb_rst = 1'b1;
    settle();
    rd(4'hF, 32'h0, "midrst_status");
    check("midrst_irq_count", irq_hi, 0);

    // Wrong block address is never acknowledged
    @(negedge wb_clk);
    cyc = 1'b1; adr = {ADDR + 8'd1, 24'h00_003C};
    acks = 0;
    repeat (6) begin
      @(posedge wb_clk); #1;
      if (ack === 1'b1) acks++;
    end
    @(negedge wb_clk);
    cyc = 1'b0;
    check("wrong_addr_ack", acks, 0);

    // Full chain of 12 LEDs terminated by reset frame then end frame
    send_zeros(32);
    for (int i = 0; i < 12; i++) send_word(32'hE100_0000 + i, 32);
    send_word(32'h0, 32);
    send_word(32'hFFFF_FFFF, 32);
    settle();
    for (int i = 0; i < 12; i++) rd(4'(i), 32'hE100_0000 + i, "chain12_mem");
    rd(4'hF, 32'h0000_0C01, "chain12_status");
    check("chain12_irq_count", irq_hi, 1);
    rd(4'd12, 32'h0, "unused_idx12");
    rd(4'd14, 32'h0, "unused_idx14");
    wr(4'd3, "wr_ignored");
    rd(4'd3, 32'hE100_0003, "wr_ignored_mem3");

    // Long start frame, two LEDs, end frame
    send_zeros(40);
    send_word(32'hEF12_3456, 32);
    send_word(32'hE0AB_CDEF, 32);
    send_word(32'hFFFF_FFFF, 32);
    settle();
    rd(4'd0, 32'hEF12_3456, "two_mem0");
    rd(4'd1, 32'hE0AB_CDEF, "two_mem1");
    rd(4'd2, 32'hE100_0002, "two_mem2_kept");
    rd(4'hF, 32'h0000_0202, "two_status");
    check("two_irq_count", irq_hi, 2);

    // Overflow: 14 LED words into 12 slots
    send_zeros(32);
    for (int i = 0; i < 14; i++) send_word(32'hE200_0000 + i, 32);
    send_word(32'hFFFF_FFFF, 32);
    settle();
    rd(4'd0, 32'hE200_0000, "ovf_mem0");
    rd(4'd11, 32'hE200_000B, "ovf_mem11");
    rd(4'hF, 32'h0002_0E03, "ovf_status");
    check("ovf_irq_count", irq_hi, 3);
    wr(4'hF, "ovf_clear");
    rd(4'hF, 32'h0000_0E03, "ovf_cleared");

    // Format error after one LED word: no latch
    send_zeros(32);
    send_word(32'hE500_0000, 32);
    send_word(32'h5A5A_5A5A, 32);
    settle();
    rd(4'hF, 32'h0001_0E03, "ferr_status");
    rd(4'd0, 32'hE500_0000, "ferr_mem0");
    check("ferr_irq_count", irq_hi, 3);
    wr(4'hF, "ferr_clear");
    rd(4'hF, 32'h0000_0E03, "ferr_cleared");

    // Timeout in the middle of an LED word
    send_zeros(32);
    send_word(32'hE300_0000, 10);
    @(negedge wb_clk);
    led_ck = 1'b0;
    rd(4'hF, 32'h0100_0E03, "mid_word_status");
    repeat (TIMEOUT + 100) @(negedge wb_clk);
    rd(4'hF, 32'h0004_0E03, "tmo_status");

    // Recovery after the timeout
    send_zeros(32);
    for (int i = 0; i < 3; i++) send_word(32'hE400_0000 + i, 32);
    send_word(32'h0, 32);
    settle();
    rd(4'd0, 32'hE400_0000, "recov_mem0");
    rd(4'd2, 32'hE400_0002, "recov_mem2");
    rd(4'd3, 32'hE200_0003, "recov_mem3_kept");
    rd(4'hF, 32'h0004_0304, "recov_status");
    check("recov_irq_count", irq_hi, 4);
    wr(4'hF, "tmo_clear");
    rd(4'hF, 32'h0000_0304, "tmo_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
